// File: rtl/ex_stage_pkg.sv
// Shared opcode, result-class and reset/write constants for the execute stage.
// Also defines the divider state encoding.
package ex_stage_pkg;

    localparam logic       RST_ENABLE    = 1'b1;
    localparam logic       WRITE_ENABLE  = 1'b1;
    localparam logic       WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, sign fix-up on output.
// busy covers the issue cycle and all step cycles; ready is a one-cycle result strobe.
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   opdata1,
    input  logic [DATA_W-1:0]   opdata2,
    output logic [2*DATA_W-1:0] result,
    output logic                ready,
    output logic                busy
);

    localparam int CNT_W = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

    div_state_t        state, state_n;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] divisor, rem, quo;
    logic              neg_q, neg_r;

    logic [DATA_W:0]   shifted, diff;
    logic              step_bit;
    logic [DATA_W-1:0] step_rem;

    // Shift the next dividend bit into the partial remainder; subtract if it fits.
    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        diff     = shifted - {1'b0, divisor};
        step_bit = ~diff[DATA_W];
        step_rem = step_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        ready   = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start) begin
                    busy    = 1'b1;
                    state_n = (opdata2 == '0) ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                busy = 1'b1;
                if (count == CNT_W'(DIV_STEPS - 1)) begin
                    state_n = DIV_DONE;
                end
            end
            DIV_DONE: begin
                ready   = 1'b1;
                state_n = DIV_IDLE;
            end
            default: state_n = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            count   <= '0;
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            count <= '0;
            rem   <= '0;
            if (opdata2 == '0) begin
                divisor <= '0;
                quo     <= '0;
                neg_q   <= 1'b0;
                neg_r   <= 1'b0;
            end else begin
                quo     <= (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
                divisor <= (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;
                neg_q   <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                neg_r   <= signed_div && opdata1[DATA_W-1];
            end
        end else if (state == DIV_BUSY) begin
            rem   <= step_rem;
            quo   <= {quo[DATA_W-2:0], step_bit};
            count <= count + 1'b1;
        end
    end

    // Remainder takes the dividend's sign; quotient is negative when signs differ.
    assign result = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU for logic/shift/arith, iterative divider for DIV/DIVU.
// Stalls the pipeline from divide issue until the HI/LO result cycle.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o
);

    logic [DATA_W-1:0]   logic_res, shift_res, arith_res, alu_res;
    logic [4:0]          shamt;
    logic                div_start, div_signed, div_ready, div_busy;
    logic [2*DATA_W-1:0] div_result;

    assign shamt      = reg1_i[4:0];
    assign div_start  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign div_signed = (aluop_i == EXE_DIV_OP);

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        case (aluop_i)
            EXE_OR_OP:   logic_res = reg1_i | reg2_i;
            EXE_AND_OP:  logic_res = reg1_i & reg2_i;
            EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
            EXE_SLL_OP:  shift_res = reg2_i << shamt;
            EXE_SRL_OP:  shift_res = reg2_i >> shamt;
            EXE_SRA_OP:  shift_res = DATA_W'($signed(reg2_i) >>> shamt);
            EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
            EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
            EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, reg1_i < reg2_i};
            default: ;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alusel_i)
            EXE_RES_LOGIC: alu_res = logic_res;
            EXE_RES_SHIFT: alu_res = shift_res;
            EXE_RES_ARITH: alu_res = arith_res;
            default:       alu_res = '0;
        endcase
    end

    div_iter #(
        .DATA_W    (DATA_W),
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .signed_div (div_signed),
        .opdata1    (reg1_i),
        .opdata2    (reg2_i),
        .result     (div_result),
        .ready      (div_ready),
        .busy       (div_busy)
    );

    // Outputs are forced quiet for the whole reset window, even with live inputs.
    always_comb begin
        wd_o       = NOP_REG_ADDR;
        wreg_o     = WRITE_DISABLE;
        wdata_o    = ZERO_WORD;
        whilo_o    = 1'b0;
        hi_o       = ZERO_WORD;
        lo_o       = ZERO_WORD;
        stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i;
            wdata_o    = alu_res;
            stallreq_o = div_busy;
            if (div_ready) begin
                whilo_o = 1'b1;
                hi_o    = div_result[2*DATA_W-1:DATA_W];
                lo_o    = div_result[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus queues expectations, a negedge monitor retires them.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, stallreq_o;

    logic        issue_vld;
    int          checks = 0;
    int          failures = 0;

    string       alu_name_q[$];
    logic [31:0] alu_q[$];
    logic [4:0]  wd_q[$];
    string       div_name_q[$];
    logic [31:0] div_lo_q[$];
    logic [31:0] div_hi_q[$];

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(32), .DIV_STEPS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: ALU results whenever an ALU op is presented, HI/LO whenever whilo_o fires.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (issue_vld) begin
                if (alu_q.size() == 0) begin
                    check("alu_queue_underflow", 32'd1, 32'd0);
                end else begin
                    string nm;
                    nm = alu_name_q.pop_front();
                    check(nm, wdata_o, alu_q.pop_front());
                    check({nm, "_wd"}, {27'b0, wd_o}, {27'b0, wd_q.pop_front()});
                    check({nm, "_stall"}, {31'b0, stallreq_o}, 32'd0);
                    check({nm, "_whilo"}, {31'b0, whilo_o}, 32'd0);
                end
            end
            if (whilo_o) begin
                if (div_lo_q.size() == 0) begin
                    check("div_queue_underflow", 32'd1, 32'd0);
                end else begin
                    string nm;
                    nm = div_name_q.pop_front();
                    check({nm, "_lo"}, lo_o, div_lo_q.pop_front());
                    check({nm, "_hi"}, hi_o, div_hi_q.pop_front());
                    check({nm, "_stall_done"}, {31'b0, stallreq_o}, 32'd0);
                end
            end
        end
    end

    task automatic alu_op(input string name, input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                          input logic [31:0] exp);
        @(posedge clk);
        #1;
        aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2;
        wd_i = wd; wreg_i = 1'b1; issue_vld = 1'b1;
        alu_name_q.push_back(name);
        alu_q.push_back(exp);
        wd_q.push_back(wd);
    endtask

    task automatic div_op(input string name, input logic sgn, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int exp_stall);
        int  n;
        logic done;
        @(posedge clk);
        #1;
        aluop_i = sgn ? EXE_DIV_OP : EXE_DIVU_OP; alusel_i = EXE_RES_NOP;
        reg1_i = r1; reg2_i = r2; wd_i = 5'd0; wreg_i = 1'b0; issue_vld = 1'b0;
        div_name_q.push_back(name);
        div_lo_q.push_back(exp_lo);
        div_hi_q.push_back(exp_hi);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (stallreq_o) n++;
            else done = 1'b1;
        end
        if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
        check({name, "_stall_cycles"}, n, exp_stall);
    endtask

    task automatic nop_check(input string name);
        @(posedge clk);
        #1;
        aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP; issue_vld = 1'b0;
        @(negedge clk);
        check({name, "_whilo"}, {31'b0, whilo_o}, 32'd0);
        check({name, "_stall"}, {31'b0, stallreq_o}, 32'd0);
        check({name, "_lo"}, lo_o, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        issue_vld = 1'b0;
        aluop_i = EXE_OR_OP; alusel_i = EXE_RES_LOGIC;
        reg1_i = 32'h1234_5678; reg2_i = 32'h0000_0001; wd_i = 5'd9; wreg_i = 1'b1;
        #3;
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_wd", {27'b0, wd_o}, 32'd0);
        check("rst_wreg", {31'b0, wreg_o}, 32'd0);
        check("rst_stall", {31'b0, stallreq_o}, 32'd0);
        check("rst_whilo", {31'b0, whilo_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        alu_op("or",        EXE_OR_OP,   EXE_RES_LOGIC, 32'h0000_FFFF, 32'hFF00_FF00, 5'd1, 32'hFF00_FFFF);
        alu_op("and",       EXE_AND_OP,  EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2, 32'hF000_F000);
        alu_op("xor",       EXE_XOR_OP,  EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3, 32'h0FF0_0FF0);
        alu_op("nor",       EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0000_FFFF, 32'hFF00_FF00, 5'd4, 32'h00FF_0000);
        alu_op("subu",      EXE_SUBU_OP, EXE_RES_ARITH, 32'h0000_0000, 32'h0000_0001, 5'd5, 32'hFFFF_FFFF);
        alu_op("addu_wrap", EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6, 32'h0000_0001);
        alu_op("slt",       EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd7, 32'h0000_0001);
        alu_op("sltu",      EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd8, 32'h0000_0000);
        alu_op("sra",       EXE_SRA_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 5'd9, 32'hF800_0000);
        alu_op("srl",       EXE_SRL_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 5'd10, 32'h0800_0000);
        alu_op("srl_shamt", EXE_SRL_OP,  EXE_RES_SHIFT, 32'h0000_0024, 32'h8000_0000, 5'd11, 32'h0800_0000);
        alu_op("sll",       EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h0000_000F, 5'd12, 32'h0000_00F0);
        alu_op("bad_sel",   EXE_OR_OP,   3'b111,        32'h0000_FFFF, 32'hFF00_FF00, 5'd13, 32'h0000_0000);

        div_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        nop_check("after_divu");
        div_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        div_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33);
        div_op("div_by_zero", 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1);
        alu_op("addu_b2b", EXE_ADDU_OP, EXE_RES_ARITH, 32'd3, 32'd4, 5'd14, 32'd7);

        // Abort a divide with reset while the step counter sits at 10.
        @(posedge clk);
        #1;
        issue_vld = 1'b0;
        aluop_i = EXE_DIVU_OP; alusel_i = EXE_RES_NOP;
        reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd5; wreg_i = 1'b1;
        repeat (11) @(posedge clk);
        #2;
        check("busy_before_rst", {31'b0, stallreq_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_stall", {31'b0, stallreq_o}, 32'd0);
        check("midrst_wd", {27'b0, wd_o}, 32'd0);
        check("midrst_wreg", {31'b0, wreg_o}, 32'd0);
        check("midrst_whilo", {31'b0, whilo_o}, 32'd0);
        aluop_i = EXE_NOP_OP;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_stall", {31'b0, stallreq_o}, 32'd0);
        check("post_rst_whilo", {31'b0, whilo_o}, 32'd0);
        repeat (3) @(negedge clk);
        check("post_rst_no_result", {31'b0, whilo_o}, 32'd0);

        check("alu_q_drained", alu_q.size(), 32'd0);
        check("div_q_drained", div_lo_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
